// File: rtl/mux2_serializer.sv
// Parallel-to-serial frame generator feeding a 2:1 mux stage: ser_bit drives mux d1, ser_sel drives mux sel.
// Shifts a WIDTH-bit word out LSB-first, with an optional trailing parity bit and a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for a word; in_ready high, serial outputs low
// DATA  | shifting data bits 0..WIDTH-1 onto ser_bit
// PAR   | driving the parity bit (only when PARITY_EN=1)
module mux2_serializer #(
  parameter int WIDTH      = 8,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       ser_bit,
  output logic                       ser_sel,
  output logic [$clog2(WIDTH+1)-1:0] bit_idx,
  output logic                       done
);

  localparam int IW = $clog2(WIDTH+1);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             par_bit;

  assign in_ready = (state == S_IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      cnt     <= '0;
      par_bit <= 1'b0;
      ser_bit <= 1'b0;
      ser_sel <= 1'b0;
      bit_idx <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            // bit 0 goes out directly; shreg holds the bits still to come
            state   <= S_DATA;
            ser_bit <= in_data[0];
            ser_sel <= 1'b1;
            bit_idx <= '0;
            shreg   <= in_data >> 1;
            cnt     <= CW'(WIDTH-1);
            par_bit <= (^in_data) ^ (ODD_PARITY != 0);
          end
        end
        S_DATA: begin
          // cnt counts data bits remaining after the one currently on ser_bit
          if (cnt != '0) begin
            ser_bit <= shreg[0];
            shreg   <= shreg >> 1;
            cnt     <= cnt - CW'(1);
            bit_idx <= bit_idx + IW'(1);
          end else if (PARITY_EN != 0) begin
            state   <= S_PAR;
            ser_bit <= par_bit;
            bit_idx <= IW'(WIDTH);
          end else begin
            state   <= S_IDLE;
            ser_bit <= 1'b0;
            ser_sel <= 1'b0;
            bit_idx <= '0;
            done    <= 1'b1;
          end
        end
        S_PAR: begin
          state   <= S_IDLE;
          ser_bit <= 1'b0;
          ser_sel <= 1'b0;
          bit_idx <= '0;
          done    <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          ser_bit <= 1'b0;
          ser_sel <= 1'b0;
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_serializer.sv
// Directed bench for mux2_serializer: even, odd and no-parity instances share clock and reset;
// a behavioural 2:1 mux with d0=1 models the downstream stage.
module tb_mux2_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       v_e = 1'b0, v_o = 1'b0, v_n = 1'b0;

  logic       sb_e, ss_e, dn_e, rd_e;
  logic       sb_o, ss_o, dn_o, rd_o;
  logic       sb_n, ss_n, dn_n, rd_n;
  logic [3:0] bi_e, bi_o, bi_n;
  logic       z;

  int checks = 0;
  int errors = 0;

  always #50 clk = ~clk;

  assign z = ss_e ? sb_e : 1'b1;

  mux2_serializer #(.WIDTH(8), .PARITY_EN(1), .ODD_PARITY(0)) u_even (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(v_e), .in_ready(rd_e),
    .ser_bit(sb_e), .ser_sel(ss_e), .bit_idx(bi_e), .done(dn_e));

  mux2_serializer #(.WIDTH(8), .PARITY_EN(1), .ODD_PARITY(1)) u_odd (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(v_o), .in_ready(rd_o),
    .ser_bit(sb_o), .ser_sel(ss_o), .bit_idx(bi_o), .done(dn_o));

  mux2_serializer #(.WIDTH(8), .PARITY_EN(0), .ODD_PARITY(0)) u_np (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(v_n), .in_ready(rd_n),
    .ser_bit(sb_n), .ser_sel(ss_n), .bit_idx(bi_n), .done(dn_n));

  typedef struct {
    logic [7:0] data;
    logic       par_even;
    logic       par_odd;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sends d to u_even (and u_odd when odd_too) and checks every serial cycle plus the done cycle.
  task automatic frame(input logic [7:0] d, input logic pe, input logic po, input bit odd_too);
    logic eb, ob;
    @(negedge clk);
    chk("ready_before", rd_e, 1);
    chk("mux_idle", z, 1);
    din = d;
    v_e = 1'b1;
    v_o = odd_too;
    @(posedge clk);
    @(negedge clk);
    v_e = 1'b0;
    v_o = 1'b0;
    for (int k = 0; k < 9; k++) begin
      eb = (k < 8) ? d[k] : pe;
      ob = (k < 8) ? d[k] : po;
      chk("ser_bit", sb_e, eb);
      chk("ser_sel", ss_e, 1);
      chk("bit_idx", bi_e, k);
      chk("done_busy", dn_e, 0);
      chk("ready_busy", rd_e, 0);
      chk("mux_z", z, eb);
      if (odd_too) begin
        chk("odd_bit", sb_o, ob);
        chk("odd_idx", bi_o, k);
      end
      @(negedge clk);
    end
    chk("done_pulse", dn_e, 1);
    chk("sel_done", ss_e, 0);
    chk("bit_done", sb_e, 0);
    chk("idx_done", bi_e, 0);
    chk("ready_done", rd_e, 1);
    chk("mux_after", z, 1);
    if (odd_too) chk("odd_done", dn_o, 1);
    @(negedge clk);
    chk("done_once", dn_e, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(rd_e && rd_o && rd_n && !ss_e && !ss_o && !ss_n) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (n < 30), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 8'hA5, par_even: 1'b0, par_odd: 1'b1};
    vecs[1] = '{data: 8'h01, par_even: 1'b1, par_odd: 1'b0};
    vecs[2] = '{data: 8'h00, par_even: 1'b0, par_odd: 1'b1};
    vecs[3] = '{data: 8'hFF, par_even: 1'b0, par_odd: 1'b1};
    vecs[4] = '{data: 8'h80, par_even: 1'b1, par_odd: 1'b0};

    // reset held with clock running
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_bit", sb_e, 0);
      chk("rst_sel", ss_e, 0);
      chk("rst_idx", bi_e, 0);
      chk("rst_done", dn_e, 0);
      chk("rst_ready", rd_e, 0);
      chk("rst_ready_np", rd_n, 0);
    end
    rst = 1'b0;
    #1;
    chk("ready_release", rd_e, 1);
    chk("ready_release_np", rd_n, 1);

    for (int i = 0; i < 5; i++)
      frame(vecs[i].data, vecs[i].par_even, vecs[i].par_odd, 1'b1);

    // no-parity, valid held high: back-to-back frames, busy-time data changes ignored
    @(negedge clk);
    din = 8'hFF;
    v_n = 1'b1;
    @(posedge clk);
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 9; c++) begin
        @(negedge clk);
        if (c == 2) din = 8'h00;
        if (c == 7) din = 8'hFF;
        if (c < 8) begin
          chk("np_bit", sb_n, 1);
          chk("np_sel", ss_n, 1);
          chk("np_idx", bi_n, c);
          chk("np_done_busy", dn_n, 0);
        end else begin
          chk("np_gap_sel", ss_n, 0);
          chk("np_done", dn_n, 1);
          chk("np_ready", rd_n, 1);
        end
      end
    end
    @(negedge clk);
    v_n = 1'b0;
    chk("np_restart_sel", ss_n, 1);
    chk("np_restart_idx", bi_n, 0);
    wait_idle();

    // reset mid-frame at bit_idx 3 of 0x3C (bit 3 is 1)
    @(negedge clk);
    din = 8'h3C;
    v_e = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v_e = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("mid_idx", bi_e, 3);
    chk("mid_bit", sb_e, 1);
    #10 rst = 1'b1;
    #1;
    chk("abort_sel", ss_e, 0);
    chk("abort_bit", sb_e, 0);
    chk("abort_idx", bi_e, 0);
    chk("abort_ready", rd_e, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_no_done", dn_e, 0);
    end
    rst = 1'b0;
    #1;
    chk("abort_release_ready", rd_e, 1);
    chk("abort_release_done", dn_e, 0);
    frame(8'h5A, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
